// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core with req/ack instruction and data ports.
// Optional macro CPU_SIGNED_CMP_EN: gt/lt use a two's-complement signed compare.
`timescale 1ns/1ps
module cpu_core_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned REG_N  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              za,
    output logic              zb,
    output logic              eq,
    output logic              gt,
    output logic              lt,
    output logic              halted,
    output logic              fault
);
    localparam int unsigned IW   = 16;
    localparam int unsigned RF_N = 8;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_FETCH2, S_MEM, S_EXEC, S_WB, S_HALT, S_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [IW-1:0]     ir_q, ext_q;
    logic [DATA_W-1:0] mdr_q, res_q;
    logic [DATA_W-1:0] rf_q [RF_N];
    logic              za_q, zb_q, eq_q, gt_q, lt_q;

    logic [1:0] len, mode, ot;
    logic [2:0] rd, rs;
    logic [3:0] op;
    assign len  = ir_q[15:14];
    assign mode = ir_q[13:12];
    assign ot   = ir_q[11:10];
    assign rd   = ir_q[9:7];
    assign rs   = ir_q[6:4];
    assign op   = ir_q[3:0];

    logic is_move, is_arith, is_logic, is_st, is_halt, is_jmp, is_jz;
    logic wr_rd, take_jump, op_ok, len_ok, reg_ok, illegal;
    assign is_move   = (ot == 2'b00);
    assign is_arith  = (ot == 2'b01);
    assign is_logic  = (ot == 2'b10);
    assign is_st     = is_move && (op == 4'h3);
    assign is_halt   = is_move && (op == 4'hF);
    assign is_jmp    = is_move && (op == 4'h1);
    assign is_jz     = is_move && (op == 4'h2);
    assign wr_rd     = (is_move && op == 4'h0) || (is_arith && op != 4'h4) || is_logic;
    assign take_jump = is_jmp || (is_jz && za_q);

    // Legality: opcode within its group, length matching mode, register indices in range
    always_comb begin : legality
        op_ok = 1'b0;
        case (ot)
            2'b00:   op_ok = (op <= 4'h2) || (op == 4'h3 && mode == 2'b10) || (op == 4'hF);
            2'b01:   op_ok = (op <= 4'h4);
            2'b10:   op_ok = (op <= 4'h5);
            default: op_ok = 1'b0;
        endcase
        len_ok  = (mode == 2'b00) ? (len == 2'b01) : (mode != 2'b11 && len == 2'b10);
        reg_ok  = (32'(rd) < REG_N) && (mode != 2'b00 || 32'(rs) < REG_N);
        illegal = !(op_ok && len_ok && reg_ok);
    end

    logic [DATA_W-1:0] a, b, alu_res;
    logic              a_gt_b, a_lt_b;
    assign a = rf_q[rd];

    always_comb begin : operand_b
        b = mdr_q;
        case (mode)
            2'b00:   b = rf_q[rs];
            2'b01:   b = DATA_W'(ext_q);
            default: b = mdr_q;
        endcase
    end

    always_comb begin : alu
        alu_res = b;
        if (is_arith) begin
            case (op)
                4'h0:    alu_res = a + b;
                4'h1:    alu_res = a - b;
                4'h2:    alu_res = a + DATA_W'(1);
                4'h3:    alu_res = a - DATA_W'(1);
                default: alu_res = a;
            endcase
        end else if (is_logic) begin
            case (op)
                4'h0:    alu_res = a & b;
                4'h1:    alu_res = a | b;
                4'h2:    alu_res = a ^ b;
                4'h3:    alu_res = ~a;
                4'h4:    alu_res = a << 1;
                4'h5:    alu_res = a >> 1;
                default: alu_res = a;
            endcase
        end
    end

`ifdef CPU_SIGNED_CMP_EN
    assign a_gt_b = $signed(a) > $signed(b);
    assign a_lt_b = $signed(a) < $signed(b);
`else
    assign a_gt_b = a > b;
    assign a_lt_b = a < b;
`endif

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_req && imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (illegal)            state_d = S_FAULT;
                else if (len == 2'b10)  state_d = S_FETCH2;
                else                    state_d = S_EXEC;
            end
            S_FETCH2: if (imem_ack) state_d = (mode == 2'b10 && !is_st) ? S_MEM : S_EXEC;
            S_MEM:    if (dmem_ack) state_d = S_EXEC;
            S_EXEC:   if (!is_st || dmem_ack) state_d = S_WB;
            S_WB:     state_d = is_halt ? S_HALT : S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_FAULT:  state_d = S_FAULT;
        endcase
    end

    // Requests decode from state; rst gates the fetch request so it drops at once
    always_comb begin : outputs
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_FETCH:  imem_req = en && !rst;
            S_FETCH2: imem_req = 1'b1;
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_addr = ADDR_W'(ext_q);
            end
            S_EXEC: if (is_st) begin
                dmem_req   = 1'b1;
                dmem_we    = 1'b1;
                dmem_addr  = ADDR_W'(ext_q);
                dmem_wdata = a;
            end
            S_HALT:   halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default:  ;
        endcase
        za = za_q;
        zb = zb_q;
        eq = eq_q;
        gt = gt_q;
        lt = lt_q;
    end

    always_ff @(posedge clk or posedge rst) begin : datapath
        if (rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            ext_q <= '0;
            mdr_q <= '0;
            res_q <= '0;
            za_q  <= 1'b0;
            zb_q  <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            for (int unsigned i = 0; i < RF_N; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (imem_req && imem_ack) begin
                    ir_q <= imem_data;
                    pc_q <= pc_q + ADDR_W'(1);
                end
                S_FETCH2: if (imem_ack) begin
                    ext_q <= imem_data;
                    pc_q  <= pc_q + ADDR_W'(1);
                end
                S_MEM: if (dmem_ack) mdr_q <= dmem_rdata;
                S_EXEC: begin
                    res_q <= alu_res;
                    if (is_arith || is_logic) begin
                        za_q <= (a == '0);
                        zb_q <= (b == '0);
                        eq_q <= (a == b);
                        gt_q <= a_gt_b;
                        lt_q <= a_lt_b;
                    end
                end
                S_WB: begin
                    if (wr_rd)     rf_q[rd] <= res_q;
                    if (take_jump) pc_q     <= ADDR_W'(res_q);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_param.sv
// Directed self-checking bench for cpu_core_param with req/ack memory models.
`timescale 1ns/1ps
module tb_cpu_core_param;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam logic [15:0] HALT_W = 16'h400F;
`ifdef CPU_SIGNED_CMP_EN
    localparam logic [4:0] CMP_FLAGS = 5'b00001;
`else
    localparam logic [4:0] CMP_FLAGS = 5'b00010;
`endif

    logic          clk = 1'b0;
    logic          rst, en;
    logic [AW-1:0] imem_addr, dmem_addr;
    logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [15:0]   imem_data;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          za, zb, eq, gt, lt, halted, fault;

    logic [AW-1:0] s_imem_addr, s_dmem_addr;
    logic          s_imem_req, s_dmem_req, s_dmem_we;
    logic [DW-1:0] s_dmem_wdata;
    logic          s_za, s_zb, s_eq, s_gt, s_lt, s_halted, s_fault;

    logic [15:0] imem [65536];
    logic [15:0] dmem [65536];
    logic        imem_hold = 1'b0;
    int unsigned dly = 0;
    int unsigned dwait = 0;
    int          cyc = 0;
    logic [15:0] fq[$];
    int          fcq[$];
    int          rd_cnt = 0, wr_req_cnt = 0, wr_cnt = 0;
    logic [15:0] wr_addr = '0, wr_data = '0;
    int          vec = 0, miss = 0;

    always #5 clk = ~clk;

    cpu_core_param #(.DATA_W(DW), .ADDR_W(AW), .REG_N(8)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .halted(halted), .fault(fault)
    );

    // Four-register variant fed a constant MOV R7,R0 word
    cpu_core_param #(.DATA_W(DW), .ADDR_W(AW), .REG_N(4)) u_small (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(s_imem_addr), .imem_req(s_imem_req), .imem_ack(s_imem_req), .imem_data(16'h4380),
        .dmem_addr(s_dmem_addr), .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_wdata(s_dmem_wdata),
        .dmem_ack(1'b0), .dmem_rdata(16'h0000),
        .za(s_za), .zb(s_zb), .eq(s_eq), .gt(s_gt), .lt(s_lt), .halted(s_halted), .fault(s_fault)
    );

    assign imem_ack   = imem_req && !imem_hold;
    assign imem_data  = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dwait >= dly);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        dwait <= (dmem_req && !dmem_ack) ? dwait + 1 : 0;
        if (imem_req && imem_ack) begin
            fq.push_back(imem_addr);
            fcq.push_back(cyc);
        end
        if (dmem_req && !dmem_we) rd_cnt = rd_cnt + 1;
        if (dmem_req && dmem_we) begin
            wr_req_cnt = wr_req_cnt + 1;
            if (dmem_ack) begin
                dmem[dmem_addr] = dmem_wdata;
                wr_addr = dmem_addr;
                wr_data = dmem_wdata;
                wr_cnt  = wr_cnt + 1;
            end
        end
    end

    function automatic logic [15:0] enc(input logic [1:0] len, input logic [1:0] mode,
                                        input logic [1:0] ot, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [3:0] op);
        return {len, mode, ot, rd, rs, op};
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 65536; i++) begin
            imem[i] = HALT_W;
            dmem[i] = 16'h0000;
        end
    endtask

    task automatic start_prog();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        fq.delete();
        fcq.delete();
        rd_cnt = 0; wr_req_cnt = 0; wr_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int n = 0;
        while (!(halted || fault) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!(halted || fault)) begin
            vec++; miss++;
            $display("FAIL %s_timeout: no halt/fault after %0d cycles", name, maxc);
        end
    endtask

    task automatic test_reset();
        logic [15:0] first;
        clear_mems();
        rst = 1'b1; en = 1'b1; imem_hold = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            miss++; $display("FAIL fetch_pending: req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
        end
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({imem_req, dmem_req, dmem_we, halted, fault, za, zb, eq, gt, lt} !== 10'b0) begin
            miss++; $display("FAIL reset_ctrl: got %b want 0000000000",
                             {imem_req, dmem_req, dmem_we, halted, fault, za, zb, eq, gt, lt});
        end
        vec++;
        if ({imem_addr, dmem_addr, dmem_wdata} !== 48'h0) begin
            miss++; $display("FAIL reset_bus: got %h want 0", {imem_addr, dmem_addr, dmem_wdata});
        end
        @(negedge clk);
        fq.delete();
        imem_hold = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        first = (fq.size() > 0) ? fq[0] : 16'hDEAD;
        vec++;
        if (first !== 16'h0000) begin
            miss++; $display("FAIL first_fetch: got %h want 0000", first);
        end
        wait_done(50, "reset");
    endtask

    task automatic test_arith();
        int d;
        clear_mems();
        imem[0] = enc(2'b10, 2'b01, 2'b00, 3'd1, 3'd0, 4'h0); imem[1] = 16'h00FF;
        imem[2] = enc(2'b10, 2'b01, 2'b00, 3'd2, 3'd0, 4'h0); imem[3] = 16'h0001;
        imem[4] = enc(2'b01, 2'b00, 2'b01, 3'd1, 3'd2, 4'h0);
        imem[5] = enc(2'b10, 2'b10, 2'b00, 3'd1, 3'd0, 4'h3); imem[6] = 16'h0020;
        start_prog();
        wait_done(100, "arith");
        vec++;
        if (dmem[16'h0020] !== 16'h0100) begin
            miss++; $display("FAIL add_result: got %h want 0100", dmem[16'h0020]);
        end
        vec++;
        if ({za, zb, eq, gt, lt} !== 5'b00010) begin
            miss++; $display("FAIL add_flags: got %b want 00010", {za, zb, eq, gt, lt});
        end
        d = (fcq.size() > 5) ? fcq[5] - fcq[4] : -1;
        vec++;
        if (d !== 4) begin
            miss++; $display("FAIL reg_insn_cycles: got %0d want 4", d);
        end
        d = (fcq.size() > 2) ? fcq[2] - fcq[0] : -1;
        vec++;
        if (d !== 5) begin
            miss++; $display("FAIL imm_insn_cycles: got %0d want 5", d);
        end
        imem[7] = enc(2'b01, 2'b00, 2'b01, 3'd1, 3'd1, 4'h4);
        imem[8] = enc(2'b10, 2'b10, 2'b00, 3'd1, 3'd0, 4'h3); imem[9] = 16'h0021;
        imem[10] = HALT_W;
        start_prog();
        wait_done(100, "cmp");
        vec++;
        if ({za, zb, eq, gt, lt} !== 5'b00100) begin
            miss++; $display("FAIL cmp_eq_flags: got %b want 00100", {za, zb, eq, gt, lt});
        end
        vec++;
        if (dmem[16'h0021] !== 16'h0100) begin
            miss++; $display("FAIL cmp_no_wb: got %h want 0100", dmem[16'h0021]);
        end
    endtask

    task automatic test_direct();
        clear_mems();
        dly = 3;
        dmem[16'h0030] = 16'hBEEF;
        imem[0] = enc(2'b10, 2'b10, 2'b00, 3'd3, 3'd0, 4'h0); imem[1] = 16'h0030;
        imem[2] = enc(2'b10, 2'b10, 2'b00, 3'd3, 3'd0, 4'h3); imem[3] = 16'h0040;
        start_prog();
        wait_done(100, "direct");
        vec++;
        if (rd_cnt !== 4) begin
            miss++; $display("FAIL load_req_cycles: got %0d want 4", rd_cnt);
        end
        vec++;
        if (wr_req_cnt !== 4 || wr_cnt !== 1) begin
            miss++; $display("FAIL store_handshake: got req=%0d acks=%0d want 4 and 1", wr_req_cnt, wr_cnt);
        end
        vec++;
        if (wr_addr !== 16'h0040 || wr_data !== 16'hBEEF) begin
            miss++; $display("FAIL store_bus: got addr=%h data=%h want 0040 BEEF", wr_addr, wr_data);
        end
        vec++;
        if ({za, zb, eq, gt, lt} !== 5'b00000) begin
            miss++; $display("FAIL move_keeps_flags: got %b want 00000", {za, zb, eq, gt, lt});
        end
        dly = 0;
    endtask

    task automatic test_cmp_sign();
        clear_mems();
        imem[0] = enc(2'b10, 2'b01, 2'b00, 3'd4, 3'd0, 4'h0); imem[1] = 16'h8000;
        imem[2] = enc(2'b10, 2'b01, 2'b00, 3'd5, 3'd0, 4'h0); imem[3] = 16'h0001;
        imem[4] = enc(2'b01, 2'b00, 2'b01, 3'd4, 3'd5, 4'h4);
        imem[5] = enc(2'b10, 2'b10, 2'b00, 3'd4, 3'd0, 4'h3); imem[6] = 16'h0060;
        start_prog();
        wait_done(100, "cmp_sign");
        vec++;
        if ({za, zb, eq, gt, lt} !== CMP_FLAGS) begin
            miss++; $display("FAIL cmp_sign_flags: got %b want %b", {za, zb, eq, gt, lt}, CMP_FLAGS);
        end
        vec++;
        if (dmem[16'h0060] !== 16'h8000) begin
            miss++; $display("FAIL cmp_sign_r4: got %h want 8000", dmem[16'h0060]);
        end
    endtask

    task automatic test_logic();
        clear_mems();
        imem[0]  = enc(2'b10, 2'b01, 2'b00, 3'd1, 3'd0, 4'h0); imem[1] = 16'h00F0;
        imem[2]  = enc(2'b10, 2'b01, 2'b10, 3'd1, 3'd0, 4'h2); imem[3] = 16'h0FF0;
        imem[4]  = enc(2'b01, 2'b00, 2'b10, 3'd1, 3'd0, 4'h4);
        imem[5]  = enc(2'b01, 2'b00, 2'b10, 3'd1, 3'd0, 4'h3);
        imem[6]  = enc(2'b01, 2'b00, 2'b01, 3'd1, 3'd0, 4'h2);
        imem[7]  = enc(2'b10, 2'b10, 2'b00, 3'd1, 3'd0, 4'h3); imem[8] = 16'h0050;
        imem[9]  = enc(2'b01, 2'b00, 2'b10, 3'd1, 3'd0, 4'h5);
        imem[10] = enc(2'b01, 2'b00, 2'b01, 3'd1, 3'd0, 4'h3);
        imem[11] = enc(2'b10, 2'b10, 2'b00, 3'd1, 3'd0, 4'h3); imem[12] = 16'h0051;
        start_prog();
        wait_done(150, "logic");
        vec++;
        if (dmem[16'h0050] !== 16'hE200) begin
            miss++; $display("FAIL xor_shl_not_inc: got %h want E200", dmem[16'h0050]);
        end
        vec++;
        if (dmem[16'h0051] !== 16'h70FF) begin
            miss++; $display("FAIL shr_dec: got %h want 70FF", dmem[16'h0051]);
        end
        vec++;
        if ({za, zb, eq, gt, lt} !== 5'b01010) begin
            miss++; $display("FAIL dec_flags: got %b want 01010", {za, zb, eq, gt, lt});
        end
    endtask

    task automatic test_jump();
        logic [15:0] exp_a [7];
        logic [15:0] got;
        int n = 0;
        exp_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0010, 16'h0011, 16'hFFFF, 16'h0000};
        clear_mems();
        imem[0]     = enc(2'b01, 2'b00, 2'b01, 3'd1, 3'd1, 4'h1);
        imem[1]     = enc(2'b10, 2'b01, 2'b00, 3'd0, 3'd0, 4'h2); imem[2] = 16'h0010;
        imem[16'h10] = enc(2'b10, 2'b01, 2'b00, 3'd0, 3'd0, 4'h1); imem[16'h11] = 16'hFFFF;
        imem[16'hFFFF] = enc(2'b01, 2'b00, 2'b01, 3'd6, 3'd0, 4'h2);
        start_prog();
        while (fq.size() < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            got = (i < fq.size()) ? fq[i] : 16'hxxxx;
            vec++;
            if (got !== exp_a[i]) begin
                miss++; $display("FAIL jump_fetch_%0d: got %h want %h", i, got, exp_a[i]);
            end
        end
        clear_mems();
        imem[0] = enc(2'b10, 2'b01, 2'b00, 3'd1, 3'd0, 4'h0); imem[1] = 16'h0001;
        imem[2] = enc(2'b01, 2'b00, 2'b01, 3'd1, 3'd0, 4'h4);
        imem[3] = enc(2'b10, 2'b01, 2'b00, 3'd0, 3'd0, 4'h2); imem[4] = 16'h0020;
        start_prog();
        wait_done(100, "jz_not_taken");
        got = (fq.size() > 0) ? fq[fq.size()-1] : 16'hxxxx;
        vec++;
        if (got !== 16'h0005) begin
            miss++; $display("FAIL jz_not_taken: last fetch %h want 0005", got);
        end
        vec++;
        if ({za, zb, eq, gt, lt} !== 5'b01010) begin
            miss++; $display("FAIL cmp_r1_r0_flags: got %b want 01010", {za, zb, eq, gt, lt});
        end
    endtask

    task automatic test_fault();
        int n = 0;
        clear_mems();
        imem[0] = enc(2'b01, 2'b00, 2'b10, 3'd1, 3'd2, 4'hE);
        start_prog();
        wait_done(50, "fault");
        vec++;
        if (fault !== 1'b1 || halted !== 1'b0) begin
            miss++; $display("FAIL bad_opcode_fault: fault=%b halted=%b want 1 0", fault, halted);
        end
        repeat (20) begin
            @(negedge clk);
            en = ~en;
            #1;
            if (imem_req || dmem_req) n++;
        end
        vec++;
        if (n !== 0 || fq.size() !== 1) begin
            miss++; $display("FAIL fault_quiet: req cycles=%0d fetches=%0d want 0 and 1", n, fq.size());
        end
        vec++;
        if (s_fault !== 1'b1 || s_imem_req !== 1'b0) begin
            miss++; $display("FAIL rd7_regn4_fault: fault=%b req=%b want 1 0", s_fault, s_imem_req);
        end
    endtask

    task automatic test_halt();
        int n = 0;
        clear_mems();
        start_prog();
        wait_done(50, "halt");
        vec++;
        if (halted !== 1'b1 || fault !== 1'b0) begin
            miss++; $display("FAIL halt_state: halted=%b fault=%b want 1 0", halted, fault);
        end
        repeat (20) begin
            @(negedge clk);
            en = ~en;
            #1;
            if (imem_req || dmem_req || !halted) n++;
        end
        vec++;
        if (n !== 0 || fq.size() !== 1) begin
            miss++; $display("FAIL halt_terminal: bad cycles=%0d fetches=%0d want 0 and 1", n, fq.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        test_reset();
        test_arith();
        test_direct();
        test_cmp_sign();
        test_logic();
        test_jump();
        test_fault();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
